// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch-operand hazard detection and PC hold sequencing
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_is_branch,
  input  logic                  id_branch_taken,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_mem_read,
  output logic                  stall,
  output logic                  stall_twice,
  output logic                  flush_idex,
  output logic                  flush_ifid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand matches against EX and MEM destinations; register 0 is hardwired
  // and can never be the source of a hazard.
  logic rs1_ex_match;
  logic rs2_ex_match;
  logic rs1_mem_match;
  logic rs2_mem_match;
  logic ex_match;
  logic mem_match;
  logic ex_load;
  logic hz_two;
  logic hz_one;

  assign rs1_ex_match  = id_rs1_used && (id_rs1 == ex_rd)  && (ex_rd  != '0);
  assign rs2_ex_match  = id_rs2_used && (id_rs2 == ex_rd)  && (ex_rd  != '0);
  assign rs1_mem_match = id_rs1_used && (id_rs1 == mem_rd) && (mem_rd != '0);
  assign rs2_mem_match = id_rs2_used && (id_rs2 == mem_rd) && (mem_rd != '0);
  assign ex_match      = rs1_ex_match  || rs2_ex_match;
  assign mem_match     = rs1_mem_match || rs2_mem_match;
  assign ex_load       = ex_mem_read && ex_reg_write;

  // A branch comparing in ID against a load still in EX needs the data from WB,
  // two cycles away; every other dependency is resolved by a single hold.
  assign hz_two = id_is_branch && ex_load && ex_match;
  assign hz_one = (!hz_two && ex_load && ex_match)
               || (id_is_branch && ex_reg_write && !ex_mem_read && ex_match)
               || (id_is_branch && mem_mem_read && mem_match);

  // State register; reset abandons any hold sequence in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: only the two-cycle hazard leaves IDLE, then HOLD/RELEASE run unconditionally.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hz_two) state_nxt = HOLD;
      HOLD:    state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Mealy outputs; all forced low while reset is asserted.
  always_comb begin
    stall       = 1'b0;
    stall_twice = 1'b0;
    flush_idex  = 1'b0;
    flush_ifid  = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (hz_two) begin
            stall_twice = 1'b1;
            stall       = 1'b1;
            flush_idex  = 1'b1;
          end else if (hz_one) begin
            stall       = 1'b1;
            flush_idex  = 1'b1;
          end else begin
            // A stalled branch is not resolved yet, so redirect only when not stalling.
            flush_ifid  = id_branch_taken;
          end
        end
        HOLD: begin
          stall      = 1'b1;
          flush_idex = 1'b1;
          busy       = 1'b1;
        end
        RELEASE: begin
          // The PC hold counter needs stall low here to reload and clear.
          flush_ifid = id_branch_taken;
          busy       = 1'b1;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule
